// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and sequencing controller between decode and the control-vector
// pipeline register. It watches in-flight register-file writes to insert
// RAW bubbles, squashes wrong-path instructions after a taken branch, and
// injects exactly one interrupt control vector per accepted interrupt.
//
// Parameters
//   SB_DEPTH   stages between decode and RF writeback tracked (1..4)
//   FLUSH_CYC  bubble cycles after a taken branch or interrupt (1..3)
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   dec_valid           decode slot holds a real instruction
//   dec_uses_x/_y       instruction reads DX / DY
//   dec_addr_x/_y       DX / DY source registers
//   dec_rf_wr           instruction writes the register file
//   dec_wb_addr         destination register
//   ex_branch_taken     branch resolved taken in execute (one-cycle pulse)
//   int_req, int_en     interrupt request (level) and enable flag
//   stall               hold PC and IF/ID
//   flush_if            invalidate IF/ID
//   nop                 load bubble vector into control_vector_reg
//   interupt            load interrupt vector into control_vector_reg
//   int_ack             one-cycle acknowledge to the interrupt source
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int SB_DEPTH  = 2,
    parameter int FLUSH_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dec_valid,
    input  logic       dec_uses_x,
    input  logic       dec_uses_y,
    input  logic [4:0] dec_addr_x,
    input  logic [4:0] dec_addr_y,
    input  logic       dec_rf_wr,
    input  logic [4:0] dec_wb_addr,
    input  logic       ex_branch_taken,
    input  logic       int_req,
    input  logic       int_en,
    output logic       stall,
    output logic       flush_if,
    output logic       nop,
    output logic       interupt,
    output logic       int_ack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INT   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] CNT_LOAD = 2'(FLUSH_CYC);

    state_t              r_state;
    logic [1:0]          r_cnt;
    logic                r_intPend;
    logic [SB_DEPTH-1:0] r_sbValid;
    logic [4:0]          r_sbAddr [SB_DEPTH];

    logic w_sbMatch;
    logic w_rawHit;
    logic w_stall;
    logic w_flushIf;
    logic w_nop;
    logic w_interupt;
    logic w_intAck;
    logic w_issue;

    // Compare both decode source operands against every live scoreboard entry.
    always_comb begin
        w_sbMatch = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (r_sbValid[i] &&
                ((dec_uses_x && (r_sbAddr[i] == dec_addr_x)) ||
                 (dec_uses_y && (r_sbAddr[i] == dec_addr_y)))) begin
                w_sbMatch = 1'b1;
            end
        end
    end

    assign w_rawHit = dec_valid & w_sbMatch;

    // Outputs are forced low while reset is asserted so that a branch pulse
    // arriving during reset cannot leak a flush or bubble request.
    // A taken branch outranks a RAW stall: the decode instruction is wrong-path.
    always_comb begin
        w_stall    = 1'b0;
        w_flushIf  = 1'b0;
        w_nop      = 1'b0;
        w_interupt = 1'b0;
        w_intAck   = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (ex_branch_taken) begin
                        w_flushIf = 1'b1;
                        w_nop     = 1'b1;
                    end else if (w_rawHit) begin
                        w_stall = 1'b1;
                        w_nop   = 1'b1;
                    end
                end
                ST_INT: begin
                    w_interupt = 1'b1;
                    w_intAck   = 1'b1;
                    w_stall    = 1'b1;
                end
                ST_FLUSH: begin
                    w_nop     = 1'b1;
                    w_flushIf = 1'b1;
                end
                default: begin
                    w_stall = 1'b0;
                end
            endcase
        end
    end

    assign stall    = w_stall;
    assign flush_if = w_flushIf;
    assign nop      = w_nop;
    assign interupt = w_interupt;
    assign int_ack  = w_intAck;

    // Only instructions that actually reach the control-vector register
    // become in-flight writes; bubbles and interrupt vectors do not.
    assign w_issue = dec_valid & dec_rf_wr & ~w_nop & ~w_interupt;

    // Scoreboard shift register: one slot per stage down to writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sbValid <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_sbAddr[i] <= 5'd0;
            end
        end else begin
            r_sbValid[0] <= w_issue;
            r_sbAddr[0]  <= dec_wb_addr;
            for (int i = 1; i < SB_DEPTH; i++) begin
                r_sbValid[i] <= r_sbValid[i-1];
                r_sbAddr[i]  <= r_sbAddr[i-1];
            end
        end
    end

    // Sequencing FSM with flush counter and interrupt-pending flag.
    // The pending flag is only sampled in IDLE so a held request cannot
    // re-arm while the previous interrupt is still being sequenced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 2'd0;
            r_intPend <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ex_branch_taken) begin
                        r_state <= ST_FLUSH;
                        r_cnt   <= CNT_LOAD;
                    end else if (r_intPend && int_en && !w_rawHit) begin
                        r_state <= ST_INT;
                    end
                end
                ST_INT: begin
                    r_state <= ST_FLUSH;
                    r_cnt   <= CNT_LOAD;
                end
                ST_FLUSH: begin
                    if (ex_branch_taken) begin
                        r_cnt <= CNT_LOAD;
                    end else if (r_cnt <= 2'd1) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 2'd0;
                end
            endcase

            if (r_state == ST_INT) begin
                r_intPend <= 1'b0;
            end else if ((r_state == ST_IDLE) && int_req && int_en) begin
                r_intPend <= 1'b1;
            end
        end
    end

endmodule
